// File: rtl/cpu_axi_bridge.sv
// Bridges NUM_RD_CH sram-like read ports and one sram-like write port onto a
// single AXI master. Single-beat transfers; one outstanding read per port.
module cpu_axi_bridge #(
  parameter int NUM_RD_CH = 2,
  parameter int ID_W      = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_RD_CH-1:0]      rd_req,
  input  logic [32*NUM_RD_CH-1:0]   rd_addr,
  input  logic [2*NUM_RD_CH-1:0]    rd_size,
  output logic [NUM_RD_CH-1:0]      rd_addr_ok,
  output logic [NUM_RD_CH-1:0]      rd_data_ok,
  output logic [32*NUM_RD_CH-1:0]   rd_rdata,
  input  logic                      wr_req,
  input  logic [31:0]               wr_addr,
  input  logic [1:0]                wr_size,
  input  logic [3:0]                wr_wstrb,
  input  logic [31:0]               wr_wdata,
  output logic                      wr_addr_ok,
  output logic                      wr_data_ok,
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [ID_W-1:0]           awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [NUM_RD_CH-1:0]      o_dbg_rd_state,
  output logic [1:0]                o_dbg_wr_state
);

  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_WAIT = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [NUM_RD_CH-1:0]    r_rd_state;
  logic [32*NUM_RD_CH-1:0] r_rdata;
  logic                    r_arvalid;
  logic [ID_W-1:0]         r_arid;
  logic [31:0]             r_araddr;
  logic [1:0]              r_arsize;
  logic [1:0]              r_wr_state;
  logic [31:0]             r_wr_addr;
  logic [31:0]             r_wr_wdata;
  logic [1:0]              r_wr_size;
  logic [3:0]              r_wr_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;

  logic                    w_wr_accept;
  logic                    w_ar_hs;
  logic                    w_ar_free;
  logic                    w_sel_valid;
  logic [ID_W-1:0]         w_sel_idx;
  logic [31:0]             w_sel_addr;
  logic [1:0]              w_sel_size;
  logic [NUM_RD_CH-1:0]    w_cand;
  logic [NUM_RD_CH-1:0]    w_hit;

  // Every AXI channel transfers in a cycle where valid && ready; valid is held
  // with stable payload until that cycle and never waits on ready.
  assign w_wr_accept = wr_req && (r_wr_state == W_IDLE);
  assign w_ar_hs     = r_arvalid && arready;
  assign w_ar_free   = !r_arvalid || arready;

  for (genvar gi = 0; gi < NUM_RD_CH; gi++) begin : g_port
    logic [31:0] w_a;
    logic        w_haz;
    assign w_a   = rd_addr[32*gi +: 32];
    // Same-word reads wait for the pending write, including one accepted now.
    assign w_haz = ((r_wr_state != W_IDLE) && (w_a[31:2] == r_wr_addr[31:2])) ||
                   (w_wr_accept && (w_a[31:2] == wr_addr[31:2]));
    assign w_cand[gi] = rd_req[gi] && (r_rd_state[gi] == R_IDLE) && !w_haz &&
                        !(r_arvalid && (r_arid == ID_W'(gi)));
    assign w_hit[gi]      = rvalid && (rid == ID_W'(gi)) && (r_rd_state[gi] == R_WAIT);
    assign rd_addr_ok[gi] = w_ar_hs && (r_arid == ID_W'(gi));
    assign rd_data_ok[gi] = w_hit[gi];
    assign rd_rdata[32*gi +: 32] = w_hit[gi] ? rdata : r_rdata[32*gi +: 32];
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_sel_addr  = '0;
    w_sel_size  = '0;
    for (int i = 0; i < NUM_RD_CH; i++) begin
      if (w_cand[i]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = ID_W'(i);
        w_sel_addr  = rd_addr[32*i +: 32];
        w_sel_size  = rd_size[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= '0;
      r_rdata    <= '0;
    end else begin
      for (int i = 0; i < NUM_RD_CH; i++) begin
        if (rd_addr_ok[i]) begin
          r_rd_state[i] <= R_WAIT;
        end else if (w_hit[i]) begin
          r_rd_state[i]        <= R_IDLE;
          r_rdata[32*i +: 32]  <= rdata;
        end
      end
    end
  end

  // A new port may be offered in the same cycle the previous AR completes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arsize  <= '0;
    end else if (w_ar_free) begin
      r_arvalid <= w_sel_valid;
      if (w_sel_valid) begin
        r_arid   <= w_sel_idx;
        r_araddr <= w_sel_addr;
        r_arsize <= w_sel_size;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_wdata <= '0;
      r_wr_size  <= '0;
      r_wr_wstrb <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (wr_req) begin
            r_wr_addr  <= wr_addr;
            r_wr_wdata <= wr_wdata;
            r_wr_size  <= wr_size;
            r_wr_wstrb <= wr_wstrb;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_wr_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || awready) && (!r_wvalid || wready)) r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (bvalid) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign wr_addr_ok = w_wr_accept;
  assign wr_data_ok = (r_wr_state == W_RESP) && bvalid;
  assign bready     = (r_wr_state == W_RESP);

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = {1'b0, r_arsize};
  assign arvalid = r_arvalid;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign awid    = '0;
  assign awaddr  = r_wr_addr;
  assign awsize  = {1'b0, r_wr_size};
  assign awvalid = r_awvalid;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wdata   = r_wr_wdata;
  assign wstrb   = r_wr_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;

  assign o_dbg_rd_state = r_rd_state;
  assign o_dbg_wr_state = r_wr_state;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: a transaction-level model checked every
// cycle, a read-data scoreboard, and literal checks at key cycles.
module tb_cpu_axi_bridge;
  localparam int N = 2;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  rd_req;
  logic [32*N-1:0] rd_addr;
  logic [2*N-1:0]  rd_size;
  logic [N-1:0]  rd_addr_ok, rd_data_ok;
  logic [32*N-1:0] rd_rdata;
  logic          wr_req;
  logic [31:0]   wr_addr, wr_wdata;
  logic [1:0]    wr_size;
  logic [3:0]    wr_wstrb;
  logic          wr_addr_ok, wr_data_ok;
  logic [3:0]    arid, awid, rid;
  logic [31:0]   araddr, awaddr, rdata, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize, arprot, awprot;
  logic [1:0]    arburst, awburst;
  logic          arlock, awlock;
  logic [3:0]    arcache, awcache, wstrb;
  logic          arvalid, arready, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [N-1:0]  dbg_rd_state;
  logic [1:0]    dbg_wr_state;

  cpu_axi_bridge #(.NUM_RD_CH(N), .ID_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_addr_ok(rd_addr_ok), .rd_data_ok(rd_data_ok), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_wstrb(wr_wstrb),
    .wr_wdata(wr_wdata), .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready),
    .o_dbg_rd_state(dbg_rd_state), .o_dbg_wr_state(dbg_wr_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // transaction-level model: what is outstanding, what is on each bus
  logic [N-1:0] m_out     = '0;
  logic         m_ar_busy = 1'b0;
  int           m_ar_port = 0;
  logic [31:0]  m_ar_addr = '0;
  logic [1:0]   m_ar_size = '0;
  logic [31:0]  m_last [N] = '{default: 32'd0};
  logic         m_wr_busy = 1'b0, m_aw_left = 1'b0, m_w_left = 1'b0;
  logic [31:0]  m_wr_addr = '0, m_wr_data = '0;
  logic [1:0]   m_wr_size = '0;
  logic [3:0]   m_wr_strb = '0;

  logic [N-1:0]    e_aok, e_dok;
  logic [32*N-1:0] e_rdata;
  logic            e_bready, e_waok, e_wdok, found, blocked;
  int              pick;
  logic [31:0]     a_i;
  logic [41:0]     c_act, c_exp;
  logic [32:0]     sb;

  always @(negedge clk) begin
    e_aok = '0;
    if (m_ar_busy && arready) e_aok[m_ar_port] = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_dok[i] = rvalid && (rid == 4'(i)) && m_out[i];
      e_rdata[32*i +: 32] = e_dok[i] ? rdata : m_last[i];
    end
    e_bready = m_wr_busy && !m_aw_left && !m_w_left;
    e_waok   = wr_req && !m_wr_busy;
    e_wdok   = e_bready && bvalid;

    chk("arvalid", arvalid, m_ar_busy);
    if (m_ar_busy) begin
      chk("araddr", araddr, m_ar_addr);
      chk("arid", arid, 4'(m_ar_port));
      chk("arsize", arsize, {1'b0, m_ar_size});
    end
    chk("rd_addr_ok", rd_addr_ok, e_aok);
    chk("rd_data_ok", rd_data_ok, e_dok);
    chk("rd_rdata", rd_rdata, e_rdata);
    chk("awvalid", awvalid, m_aw_left);
    chk("wvalid", wvalid, m_w_left);
    chk("bready", bready, e_bready);
    chk("wr_addr_ok", wr_addr_ok, e_waok);
    chk("wr_data_ok", wr_data_ok, e_wdok);
    if (m_aw_left) begin
      chk("awaddr", awaddr, m_wr_addr);
      chk("awsize", awsize, {1'b0, m_wr_size});
    end
    if (m_w_left) begin
      chk("wdata", wdata, m_wr_data);
      chk("wstrb", wstrb, m_wr_strb);
    end
    c_act = {rready, arlen, awlen, arburst, awburst, wlast, awid, arlock, awlock,
             arcache, awcache, arprot, awprot};
    c_exp = {1'b1, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0,
             4'd0, 4'd0, 3'd0, 3'd0};
    chk("fixed_fields", c_act, c_exp);

    // scoreboard: every delivered read must be the next expected one
    for (int i = 0; i < N; i++) begin
      if (rd_data_ok[i]) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {31'd0, rd_data_ok}, 64'd0);
        end else begin
          sb = exp_q.pop_front();
          chk("sb_read", {1'(i), rd_rdata[32*i +: 32]}, sb);
        end
      end
    end

    if (!resetn) begin
      m_out = '0; m_ar_busy = 1'b0; m_ar_port = 0; m_ar_addr = '0; m_ar_size = '0;
      for (int i = 0; i < N; i++) m_last[i] = '0;
      m_wr_busy = 1'b0; m_aw_left = 1'b0; m_w_left = 1'b0;
    end else begin
      if (!m_ar_busy || arready) begin
        found = 1'b0;
        pick  = 0;
        for (int i = N - 1; i >= 0; i--) begin
          a_i = rd_addr[32*i +: 32];
          blocked = (m_wr_busy && (a_i[31:2] == m_wr_addr[31:2])) ||
                    (e_waok && (a_i[31:2] == wr_addr[31:2]));
          if (rd_req[i] && !m_out[i] && !(m_ar_busy && m_ar_port == i) && !blocked) begin
            found = 1'b1;
            pick  = i;
            break;
          end
        end
        m_ar_busy = found;
        if (found) begin
          m_ar_port = pick;
          m_ar_addr = rd_addr[32*pick +: 32];
          m_ar_size = rd_size[2*pick +: 2];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (e_dok[i]) begin
          m_out[i]  = 1'b0;
          m_last[i] = rdata;
        end
        if (e_aok[i]) m_out[i] = 1'b1;
      end
      if (e_waok) begin
        m_wr_busy = 1'b1; m_aw_left = 1'b1; m_w_left = 1'b1;
        m_wr_addr = wr_addr; m_wr_data = wr_wdata; m_wr_size = wr_size; m_wr_strb = wr_wstrb;
      end else if (m_wr_busy) begin
        if (e_bready && bvalid) m_wr_busy = 1'b0;
        if (m_aw_left && awready) m_aw_left = 1'b0;
        if (m_w_left && wready) m_w_left = 1'b0;
      end
    end
  end

  // driver
  initial begin
    resetn = 1'b0; rd_req = '0; rd_addr = '0; rd_size = '0;
    wr_req = 1'b0; wr_addr = '0; wr_size = '0; wr_wstrb = '0; wr_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step();

    // single read, port 0, request in the first cycle out of reset
    resetn = 1'b1; rd_req = 2'b01; rd_addr[31:0] = 32'h1c00_0000; rd_size[1:0] = 2'd2;
    arready = 1'b1;
    @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_awwv", {awvalid, wvalid, bready}, 0);
    chk("reset_rready", rready, 1);
    chk("reset_rdata", rd_rdata, 0);
    chk("reset_oks", {rd_addr_ok, rd_data_ok, wr_addr_ok, wr_data_ok}, 0);
    step();
    @(negedge clk);
    chk("r1_addr_ok", rd_addr_ok, 2'b01);
    chk("r1_araddr", araddr, 32'h1c00_0000);
    chk("r1_arid", arid, 0);
    step(); rd_req = '0;
    @(negedge clk); chk("r1_ar_done", arvalid, 0);
    step();
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678; exp_q.push_back({1'b0, 32'h1234_5678});
    @(negedge clk);
    chk("r1_data_ok", rd_data_ok, 2'b01);
    chk("r1_rdata", rd_rdata[31:0], 32'h1234_5678);
    step(); rvalid = 1'b0;

    // both ports at once: port 1 first, then port 0; R returns 0 then 1
    rd_req = 2'b11; rd_addr = {32'h0000_2000, 32'h0000_1000}; rd_size = 4'b1010;
    step();
    @(negedge clk);
    chk("r2_first_arid", arid, 1);
    chk("r2_first_ok", rd_addr_ok, 2'b10);
    chk("r2_first_addr", araddr, 32'h0000_2000);
    step(); rd_req = 2'b01;
    @(negedge clk);
    chk("r2_second_arid", arid, 0);
    chk("r2_second_ok", rd_addr_ok, 2'b01);
    step(); rd_req = '0; rvalid = 1'b1; rid = 4'd0; rdata = 32'hAAAA_0000;
    exp_q.push_back({1'b0, 32'hAAAA_0000});
    @(negedge clk); chk("r2_ooo0_ok", rd_data_ok, 2'b01);
    step(); rid = 4'd1; rdata = 32'hBBBB_1111; exp_q.push_back({1'b1, 32'hBBBB_1111});
    @(negedge clk);
    chk("r2_ooo1_ok", rd_data_ok, 2'b10);
    chk("r2_ooo1_data", rd_rdata[63:32], 32'hBBBB_1111);
    step(); rid = 4'd0; rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("r2_stray_ok", rd_data_ok, 2'b00);
    chk("r2_stray_hold", rd_rdata[31:0], 32'hAAAA_0000);
    step(); rid = 4'd3;
    @(negedge clk); chk("r2_badid_ok", rd_data_ok, 2'b00);
    step(); rvalid = 1'b0;

    // write with awready late, wready immediate; second wr_req ignored
    wr_req = 1'b1; wr_addr = 32'h100; wr_size = 2'd2; wr_wstrb = 4'b0011;
    wr_wdata = 32'hCAFE_F00D; awready = 1'b0; wready = 1'b1;
    @(negedge clk); chk("w1_addr_ok", wr_addr_ok, 1);
    step(); wr_req = 1'b0;
    @(negedge clk);
    chk("w1_aw_w_up", {awvalid, wvalid}, 2'b11);
    chk("w1_wstrb", wstrb, 4'b0011);
    step(); wr_req = 1'b1; wr_addr = 32'h300;
    @(negedge clk);
    chk("w1_w_drop", {awvalid, wvalid}, 2'b10);
    chk("w1_busy_ignored", wr_addr_ok, 0);
    step(); wr_req = 1'b0; awready = 1'b1;
    @(negedge clk); chk("w1_aw_held", awvalid, 1);
    step(); awready = 1'b0;
    @(negedge clk);
    chk("w1_aw_drop", awvalid, 0);
    chk("w1_bready", bready, 1);
    step(); bvalid = 1'b1;
    @(negedge clk); chk("w1_data_ok", wr_data_ok, 1);
    step(); bvalid = 1'b0;
    @(negedge clk); chk("w1_idle", {bready, wr_data_ok}, 2'b00);

    // hazard: read of same word blocked until B, other port proceeds; R and B together
    step(); wr_req = 1'b1; wr_addr = 32'h100; wr_wdata = 32'h1111_2222; wr_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    @(negedge clk); chk("h_wr_ok", wr_addr_ok, 1);
    step(); wr_req = 1'b0; rd_req = 2'b11; rd_addr = {32'h0000_0102, 32'h0000_0200};
    rd_size = 4'b1010;
    step();
    @(negedge clk);
    chk("h_port0_arid", arid, 0);
    chk("h_port0_ok", rd_addr_ok, 2'b01);
    step(); rd_req = 2'b10;
    @(negedge clk); chk("h_port1_blocked", arvalid, 0);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0055; bvalid = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0055});
    @(negedge clk);
    chk("h_r_and_b", {rd_data_ok, wr_data_ok}, 3'b011);
    chk("h_still_blocked", arvalid, 0);
    step(); rvalid = 1'b0; bvalid = 1'b0;
    @(negedge clk); chk("h_after_b", arvalid, 0);
    step();
    @(negedge clk);
    chk("h_port1_arid", arid, 1);
    chk("h_port1_addr", araddr, 32'h0000_0102);
    step(); rd_req = '0;

    // reset in the middle of a stalled AR while port 1 is still outstanding
    arready = 1'b0; rd_req = 2'b01; rd_addr[31:0] = 32'h0000_0400;
    step(); resetn = 1'b0;
    @(negedge clk); chk("rst_arvalid_before", arvalid, 1);
    step(); resetn = 1'b1; rd_req = '0; arready = 1'b1;
    @(negedge clk);
    chk("rst_arvalid_after", arvalid, 0);
    chk("rst_addr_ok", rd_addr_ok, 0);
    chk("rst_rdata", rd_rdata, 0);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0077;
    @(negedge clk); chk("rst_late_r1", rd_data_ok, 0);
    step(); rid = 4'd0;
    @(negedge clk); chk("rst_late_r0", rd_data_ok, 0);
    step(); rvalid = 1'b0;

    // read and write accepted in the same cycle
    rd_req = 2'b01; rd_addr[31:0] = 32'h0000_0800; rd_size[1:0] = 2'd2;
    wr_req = 1'b1; wr_addr = 32'h900; wr_wdata = 32'h0000_0009; wr_wstrb = 4'hF;
    @(negedge clk); chk("sim_wr_ok", wr_addr_ok, 1);
    step(); wr_req = 1'b0;
    @(negedge clk);
    chk("sim_rd_ok", rd_addr_ok, 2'b01);
    chk("sim_aw_w", {awvalid, wvalid}, 2'b11);
    step(); rd_req = '0; bvalid = 1'b1;
    @(negedge clk); chk("sim_b", wr_data_ok, 1);
    step(); bvalid = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h8080_8080;
    exp_q.push_back({1'b0, 32'h8080_8080});
    @(negedge clk); chk("sim_r", rd_data_ok, 2'b01);
    step(); rvalid = 1'b0;
    repeat (3) step();

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
